palette_bank_loader: RTL and testbench

- Double-buffered palette controller for the sprite renderer.
- Owns the live 16 x 24-bit palette that the pixel pipeline reads for color lookups, with index 0 meaning transparent.
- On request, fetches a new palette (player/pose palette N) from the shared palette ROM into a shadow bank, one entry per cycle.
- Swaps the shadow bank to live only during vblank, so no frame mixes two palettes.

---
 rtl/palette_pkg.sv | 23 ++
 rtl/palette_bank.sv | 34 +++
 rtl/palette_bank_loader.sv | 159 +++++++++++++++
 tb/tb_palette_bank_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the double-buffered sprite palette controller.
package palette_pkg;

  localparam int COLOR_W               = 24;
  localparam int PAL_ENTRIES           = 16;
  localparam int PAL_IDX_W             = 4;
  localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    PEND  = 2'd3
  } loader_state_t;

  // Requests for palettes the ROM does not hold are never accepted.
  function automatic logic id_in_range(input int id, input int num_pal);
    return (id < num_pal);
  endfunction

endpackage

// File: rtl/palette_bank.sv
// 16-entry colour register file: one synchronous write port, one registered read port.
module palette_bank
  import palette_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [PAL_IDX_W-1:0] waddr,
  input  color_t               wdata,
  input  logic                 re,
  input  logic [PAL_IDX_W-1:0] raddr,
  output color_t               rdata
);

  color_t mem [PAL_ENTRIES];

  // Storage and read register; read data holds while re is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/palette_bank_loader.sv
// Fetches a palette from ROM into the shadow bank and swaps it live during vblank;
// also serves 1-cycle colour lookups from the live bank.
module palette_bank_loader
  import palette_pkg::*;
#(
  parameter int NUM_PAL  = 8,
  parameter int PAL_ID_W = 3,
  parameter int ROM_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic [PAL_ID_W-1:0]   load_id,
  output logic                  load_ack,
  output logic                  busy,
  output logic                  rom_rd,
  output logic [PAL_ID_W+3:0]   rom_addr,
  input  color_t                rom_data,
  input  logic                  vblank,
  output logic                  swap_done,
  output logic [PAL_ID_W-1:0]   active_id,
  input  logic                  pix_valid,
  input  logic [PAL_IDX_W-1:0]  pix_idx,
  output logic                  pix_out_valid,
  output color_t                pix_color,
  output logic                  pix_opaque
);

  loader_state_t         state;
  logic [PAL_ID_W-1:0]   req_id;
  logic [3:0]            issue_k;
  logic [3:0]            write_k;
  logic [ROM_LAT-1:0]    vld_sr;
  logic                  cap_vld;
  logic                  bank_ptr;
  logic                  sel_bank;
  logic [1:0]            bank_we;
  logic [1:0]            bank_re;
  color_t                bank_rdata [2];

  assign cap_vld = vld_sr[ROM_LAT-1];

  // bank_ptr names the live bank; the other one is the shadow being filled.
  assign bank_we[0] = cap_vld & bank_ptr;
  assign bank_we[1] = cap_vld & ~bank_ptr;
  assign bank_re[0] = pix_valid & ~bank_ptr;
  assign bank_re[1] = pix_valid & bank_ptr;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    palette_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[b]),
      .waddr (write_k),
      .wdata (rom_data),
      .re    (bank_re[b]),
      .raddr (pix_idx),
      .rdata (bank_rdata[b])
    );
  end

  // Tracks which ROM reads have data arriving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= rom_rd;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // Shadow write pointer, advances once per captured ROM word.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_k <= 4'd0;
    end else if (cap_vld) begin
      write_k <= write_k + 4'd1;
    end
  end

  // Load sequencer: accept, issue 16 reads, drain, then swap on vblank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_id    <= '0;
      issue_k   <= 4'd0;
      load_ack  <= 1'b0;
      busy      <= 1'b0;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      swap_done <= 1'b0;
      active_id <= '0;
      bank_ptr  <= 1'b0;
    end else begin
      load_ack  <= 1'b0;
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_req && id_in_range(int'(load_id), NUM_PAL)) begin
            req_id   <= load_id;
            load_ack <= 1'b1;
            busy     <= 1'b1;
            rom_rd   <= 1'b1;
            rom_addr <= {load_id, 4'd0};
            issue_k  <= 4'd0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          issue_k <= issue_k + 4'd1;
          if (issue_k == 4'd15) begin
            rom_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            rom_addr <= {req_id, issue_k + 4'd1};
          end
        end
        DRAIN: begin
          if (cap_vld && (write_k == 4'd15)) begin
            state <= PEND;
          end
        end
        PEND: begin
          if (vblank) begin
            bank_ptr  <= ~bank_ptr;
            active_id <= req_id;
            swap_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Lookup side-band; bank choice is captured with the request so a swap
  // on the same edge still returns the old bank's colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out_valid <= 1'b0;
      sel_bank      <= 1'b0;
      pix_opaque    <= 1'b0;
    end else begin
      pix_out_valid <= pix_valid;
      if (pix_valid) begin
        sel_bank   <= bank_ptr;
        pix_opaque <= (pix_idx != TRANSPARENT_IDX);
      end
    end
  end

  assign pix_color = pix_opaque ? bank_rdata[sel_bank] : '0;

endmodule

// File: tb/tb_palette_bank_loader.sv
// Runs two loaders (ROM latency 1 and 3) against a palette-level reference model.
module tb_palette_bank_loader;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              vblank;
  logic              pix_valid;
  logic [3:0]        pix_idx;
  logic [N-1:0]      load_req;
  logic [2:0]        load_id   [N];
  logic [N-1:0]      load_ack, busy, rom_rd, swap_done, pix_out_valid, pix_opaque;
  logic [6:0]        rom_addr  [N];
  logic [23:0]       rom_data  [N];
  logic [2:0]        active_id [N];
  logic [23:0]       pix_color [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LG = (g == 0) ? 1 : 3;
    logic [3:0] rp_vld = 4'd0;
    logic [6:0] rp_addr [4];

    // ROM: word = A00000 | address, returned LG cycles after the read strobe
    always @(posedge clk) begin
      rp_vld     <= {rp_vld[2:0], rom_rd[g]};
      rp_addr[0] <= rom_addr[g];
      for (int k = 1; k < 4; k++) rp_addr[k] <= rp_addr[k-1];
    end
    assign rom_data[g] = rp_vld[LG-1] ? (24'hA00000 | {17'h0, rp_addr[LG-1]}) : 24'h5A5A5A;

    palette_bank_loader #(.NUM_PAL(8), .PAL_ID_W(3), .ROM_LAT(LG)) dut (
      .clk(clk), .rst(rst),
      .load_req(load_req[g]), .load_id(load_id[g]), .load_ack(load_ack[g]), .busy(busy[g]),
      .rom_rd(rom_rd[g]), .rom_addr(rom_addr[g]), .rom_data(rom_data[g]),
      .vblank(vblank), .swap_done(swap_done[g]), .active_id(active_id[g]),
      .pix_valid(pix_valid), .pix_idx(pix_idx),
      .pix_out_valid(pix_out_valid[g]), .pix_color(pix_color[g]), .pix_opaque(pix_opaque[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // reference model: which palette is live and how far a load has progressed
  bit          m_busy   [N];
  int          m_t      [N];
  logic [2:0]  m_req    [N];
  logic [2:0]  m_active [N];
  bit          m_loaded [N];
  logic        e_ack [N], e_swap [N], e_pov [N], e_opq [N];
  logic [23:0] e_color [N];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_t[i] = 0; m_req[i] = 3'd0; m_active[i] = 3'd0; m_loaded[i] = 0;
        e_ack[i] = 1'b0; e_swap[i] = 1'b0; e_pov[i] = 1'b0; e_opq[i] = 1'b0; e_color[i] = 24'h0;
      end else begin
        e_pov[i] = pix_valid;
        if (pix_valid) begin
          e_opq[i]   = (pix_idx != 4'd0);
          e_color[i] = (pix_idx == 4'd0 || !m_loaded[i]) ? 24'h0
                     : (24'hA00000 | {17'h0, m_active[i], pix_idx});
        end
        e_ack[i]  = 1'b0;
        e_swap[i] = 1'b0;
        if (!m_busy[i]) begin
          if (load_req[i]) begin
            m_busy[i] = 1; m_req[i] = load_id[i]; m_t[i] = 1; e_ack[i] = 1'b1;
          end
        end else if (vblank && m_t[i] >= 17 + lat_of(i)) begin
          m_busy[i] = 0; m_active[i] = m_req[i]; m_loaded[i] = 1; e_swap[i] = 1'b1;
        end else begin
          m_t[i]++;
        end
      end
    end
  endtask

  task automatic compare();
    logic [3:0] k;
    for (int i = 0; i < N; i++) begin
      k = 4'(m_t[i] - 1);
      chk("load_ack", i, load_ack[i], e_ack[i]);
      chk("busy", i, busy[i], m_busy[i]);
      chk("swap_done", i, swap_done[i], e_swap[i]);
      chk("active_id", i, active_id[i], m_active[i]);
      chk("pix_out_valid", i, pix_out_valid[i], e_pov[i]);
      chk("pix_color", i, pix_color[i], e_color[i]);
      chk("pix_opaque", i, pix_opaque[i], e_opq[i]);
      chk("rom_rd", i, rom_rd[i], (m_busy[i] && m_t[i] <= 16));
      if (m_busy[i] && m_t[i] <= 16) chk("rom_addr", i, rom_addr[i], {m_req[i], k});
    end
  endtask

  // inputs are already set; advance one clock and check at the falling edge
  task automatic cycle();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_swap(input string name);
    int n = 0;
    while (swap_done != 2'b11 && n < 60) begin
      cycle();
      n++;
    end
    chk(name, 0, swap_done, 2'b11);
  endtask

  initial begin
    int n_addr [N];
    rst = 1'b1; vblank = 1'b0; pix_valid = 1'b0; pix_idx = 4'd0;
    load_req = '0; load_id[0] = 3'd0; load_id[1] = 3'd0;
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;

    // lookups out of reset: black, opacity from index only
    pix_valid = 1'b1; pix_idx = 4'd5;
    cycle();
    for (int i = 0; i < N; i++) begin
      chk("pin_reset_pov", i, pix_out_valid[i], 1'b1);
      chk("pin_reset_color", i, pix_color[i], 24'h0);
      chk("pin_reset_opq", i, pix_opaque[i], 1'b1);
    end
    pix_idx = 4'd0;
    cycle();
    for (int i = 0; i < N; i++) begin
      chk("pin_idx0_opq", i, pix_opaque[i], 1'b0);
      chk("pin_reset_active", i, active_id[i], 3'd0);
      chk("pin_reset_busy", i, busy[i], 1'b0);
    end

    // load palette 3 with vblank low: 16 reads 0x30..0x3F, no swap
    load_req = 2'b11; load_id[0] = 3'd3; load_id[1] = 3'd3; pix_idx = 4'd7;
    cycle();
    for (int i = 0; i < N; i++) begin
      chk("pin_ack_id3", i, load_ack[i], 1'b1);
      n_addr[i] = 0;
    end
    load_req = 2'b00;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rom_rd[i]) begin
          chk("pin_addr_id3", i, rom_addr[i], 7'h30 + 7'(n_addr[i]));
          n_addr[i]++;
        end
      end
      cycle();
    end
    for (int i = 0; i < N; i++) begin
      chk("pin_reads_16", i, n_addr[i], 16);
      chk("pin_no_swap", i, active_id[i], 3'd0);
      chk("pin_old_color", i, pix_color[i], 24'h0);
    end

    // second request while busy is not acknowledged
    load_req = 2'b11; load_id[0] = 3'd5; load_id[1] = 3'd5;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("pin_no_ack_busy", 0, load_ack, 2'b00);
    end

    // swap edge: lookup in the same cycle still reads the old bank
    vblank = 1'b1;
    cycle();
    for (int i = 0; i < N; i++) begin
      chk("pin_swap_done", i, swap_done[i], 1'b1);
      chk("pin_swap_busy", i, busy[i], 1'b0);
      chk("pin_swap_active", i, active_id[i], 3'd3);
      chk("pin_swap_edge_color", i, pix_color[i], 24'h0);
      chk("pin_swap_no_ack", i, load_ack[i], 1'b0);
    end
    vblank = 1'b0;
    cycle();
    for (int i = 0; i < N; i++) begin
      chk("pin_new_color", i, pix_color[i], 24'hA00037);
      chk("pin_ack_after_swap", i, load_ack[i], 1'b1);
    end
    load_req = 2'b00; pix_idx = 4'd0;
    cycle();
    for (int i = 0; i < N; i++) begin
      chk("pin_idx0_color", i, pix_color[i], 24'h0);
      chk("pin_idx0_opq2", i, pix_opaque[i], 1'b0);
    end
    for (int c = 0; c < 30; c++) begin
      pix_idx = 4'($urandom_range(0, 15));
      cycle();
    end
    vblank = 1'b1;
    wait_swap("swap_id5_timeout");
    for (int i = 0; i < N; i++) chk("pin_active5", i, active_id[i], 3'd5);
    vblank = 1'b0;

    // reset in the middle of a fetch aborts it; nothing is swapped in later
    load_req = 2'b11; load_id[0] = 3'd6; load_id[1] = 3'd6;
    cycle();
    load_req = 2'b00;
    for (int c = 0; c < 8; c++) cycle();
    for (int i = 0; i < N; i++) chk("pin_addr_k8", i, rom_addr[i], 7'h68);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) chk("pin_rst_rd", i, rom_rd[i], 1'b0);
    vblank = 1'b1;
    for (int c = 0; c < 30; c++) begin
      pix_idx = 4'($urandom_range(0, 15));
      cycle();
    end
    for (int i = 0; i < N; i++) chk("pin_rst_active", i, active_id[i], 3'd0);

    // complete fetch of palette 2, then read every entry back
    vblank = 1'b0; load_req = 2'b11; load_id[0] = 3'd2; load_id[1] = 3'd2;
    cycle();
    load_req = 2'b00;
    for (int c = 0; c < 30; c++) cycle();
    vblank = 1'b1;
    wait_swap("swap_id2_timeout");
    vblank = 1'b0;
    for (int e = 1; e < 16; e++) begin
      pix_idx = 4'(e);
      cycle();
      for (int i = 0; i < N; i++) chk("pin_entry", i, pix_color[i], 24'hA00020 | 24'(e));
    end

    // randomized traffic with independent requesters
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (load_req[i] && load_ack[i]) begin
          load_req[i] = 1'b0;
        end else if (!load_req[i] && $urandom_range(0, 15) == 0) begin
          load_req[i] = 1'b1;
          load_id[i]  = 3'($urandom_range(0, 7));
        end
      end
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_idx   = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
